ultrasonic_distance_filter: RTL and testbench
=============================================

Name: ultrasonic_distance_filter

Overview:
- Conditions the raw 8-bit ultrasonic distance before it reaches the arm controller.
- Sits between the PWM pulse-width measurement stage and the FSM controller.
- Samples the raw distance at a fixed period and rejects single-sample outliers.
- Outputs a moving average over a power-of-two window, with a valid flag and a per-update strobe, so servo targets never follow echo glitches.

Parameters:
- SAMPLE_CYCLES, 5_000_000: clock cycles per sample period (50 ms at 100 MHz); minimum 2.
- DEPTH_LOG2, 2: log2 of the averaging window; window N = 2**DEPTH_LOG2.
- MAX_JUMP, 40: largest accepted absolute step (cm) between a new sample and the current distance_out.
- STALE_LIMIT, 3: number of consecutive rejected samples tolerated before the filter re-seeds.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state.
- distance_in  input  8  raw distance from the pulse-width measurement stage; may change on any cycle.
- enable  input  1  ultrasonicControlled from the mode FSM; sampling runs only while high.
- distance_out  output  8  filtered distance.
- valid  output  1  high while the window is full and distance_out is meaningful.
- update  output  1  one-cycle pulse when distance_out is rewritten.
- outlier  output  1  one-cycle pulse when a sample is rejected.

Behaviour:
- Reset (reset==0, asynchronous) clears:
  - sample counter, wr_ptr, fill, sum, reject_run;
  - all buffer entries;
  - distance_out=0, valid=0, update=0, outlier=0.
- Sample timer:
  - Counts 0..SAMPLE_CYCLES-1 while enable=1 and wraps.
  - At count SAMPLE_CYCLES-1 (cycle T), distance_in is captured into the sample register at the end of T.
  - The sample is processed in T+1; results are registered and visible from T+2.
  - update/outlier are high for exactly cycle T+2.
- enable=0: counter held at 0, no samples taken, distance_out and valid held.
- Rising edge of enable (registered compare): flush, and the counter restarts from 0.
- Flush action:
  - buffer entries, sum, fill and wr_ptr go to 0; valid goes to 0;
  - distance_out is held, not cleared;
  - reject_run goes to 0.
- Outlier test, applied only when valid=1: reject the sample if |s - distance_out| > MAX_JUMP (9-bit signed difference).
  - Reject with reject_run < STALE_LIMIT: buffer untouched, reject_run++, outlier pulse.
  - Reject with reject_run == STALE_LIMIT: flush, then accept s as the first entry (fill=1), no outlier pulse.
  - Any accepted sample clears reject_run.
  - A difference of exactly MAX_JUMP is accepted.
- Accept path:
  - sum <= sum - buf[wr_ptr] + s, with sum width 8+DEPTH_LOG2, so no overflow is possible.
  - buf[wr_ptr] <= s; wr_ptr <= (wr_ptr+1) mod N.
  - fill <= min(fill+1, N).
- Output update, when fill==N after the write:
  - distance_out <= sum_new >> DEPTH_LOG2 (truncating);
  - valid <= 1; update pulse.
- While fill < N: no update pulse, valid stays 0, distance_out holds its previous value.
- Simultaneous events:
  - Asynchronous reset wins over everything.
  - Enable rising edge in the same cycle as processing: the flush wins and the pending sample is discarded.
  - enable falling during cycle T+1: that sample still completes.
- Exactly one sample is processed per period; no back-pressure exists.

Test Plan (SAMPLE_CYCLES=4, defaults otherwise):
1. Reset: pulse reset low mid-operation after valid=1 -> all outputs 0 within the same cycle; after release, the first update comes only after 4 accepted samples.
2. Constant input: distance_in=100, enable=1 -> valid rises with distance_out=100 after the 4th sample; update then pulses every 4 cycles and is high exactly 1 cycle each time.
3. Ramp/truncation: samples 10,20,30,40 -> distance_out=25; next 50 -> 35; next 61 -> 45 (181>>2).
4. Outlier and re-seed: steady 100, then distance_in=200:
   - first 3 samples each pulse outlier, distance_out stays 100;
   - 4th sample flushes (valid=0, no outlier pulse);
   - after 3 further samples of 200, valid=1 and distance_out=200.
   Also: 140 on a steady 100 is accepted (|diff|=MAX_JUMP).
5. Enable gating: drop enable for 20 cycles -> no update, distance_out/valid held; raise enable -> valid=0 at once, refill of 4 samples, then update.
6. Saturation boundary: 4 samples of 255 -> sum=1020, distance_out=255; then samples of 0 from steady 0 after a flush -> distance_out=0, with no wrap or sign error.

Source files
------------

// File: rtl/ultrasonic_distance_filter.sv
// ultrasonic_distance_filter: periodic sampler with outlier rejection and power-of-two moving average
// Ports: clk; reset (async, active-low); distance_in raw cm; enable runs sampling;
//        distance_out filtered cm; valid window full; update / outlier one-cycle strobes
module ultrasonic_distance_filter #(
    parameter int SAMPLE_CYCLES = 5_000_000,
    parameter int DEPTH_LOG2    = 2,
    parameter int MAX_JUMP      = 40,
    parameter int STALE_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] distance_in,
    input  logic       enable,
    output logic [7:0] distance_out,
    output logic       valid,
    output logic       update,
    output logic       outlier
);
    localparam int N  = 1 << DEPTH_LOG2;
    localparam int CW = $clog2(SAMPLE_CYCLES);
    localparam int SW = 8 + DEPTH_LOG2;
    localparam int RW = $clog2(STALE_LIMIT + 2);
    localparam logic [CW-1:0]       LAST  = CW'(SAMPLE_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(N);
    localparam logic [RW-1:0]       STALE = RW'(STALE_LIMIT);
    localparam logic [8:0]          JUMP  = 9'(MAX_JUMP);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  en_q;
    logic [7:0]            sample_q, sample_d;
    logic                  pend_q, pend_d;
    logic [7:0]            mem_q [N];
    logic [7:0]            mem_d [N];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [RW-1:0]         reject_run_q, reject_run_d;
    logic [7:0]            dout_q, dout_d;
    logic                  valid_q, valid_d, update_q, update_d, outlier_q, outlier_d;
    logic [8:0]            diff, mag;
    logic                  rise, reject, stale;

    assign rise = enable && !en_q;

    always_comb begin
        cnt_d        = enable ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : '0;
        pend_d       = enable && cnt_q == LAST;
        sample_d     = pend_d ? distance_in : sample_q;
        diff         = {1'b0, sample_q} - {1'b0, dout_q};
        mag          = diff[8] ? -diff : diff;
        reject       = valid_q && mag > JUMP;
        stale        = pend_q && reject && reject_run_q == STALE;
        mem_d        = mem_q;
        sum_d        = sum_q;
        fill_d       = fill_q;
        wr_ptr_d     = wr_ptr_q;
        reject_run_d = reject_run_q;
        dout_d       = dout_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        outlier_d    = 1'b0;
        // an enable rising edge or a stale run empties the window; distance_out is kept
        if (rise || stale) begin
            mem_d        = '{default: '0};
            sum_d        = '0;
            fill_d       = '0;
            wr_ptr_d     = '0;
            valid_d      = 1'b0;
            reject_run_d = '0;
        end
        // a flush on the enable edge discards a sample pending in the same cycle
        if (pend_q && !rise) begin
            if (reject && !stale) begin
                reject_run_d = reject_run_q + 1'b1;
                outlier_d    = 1'b1;
            end else begin
                reject_run_d    = '0;
                sum_d           = sum_d - SW'(mem_d[wr_ptr_d]) + SW'(sample_q);
                mem_d[wr_ptr_d] = sample_q;
                wr_ptr_d        = wr_ptr_d + 1'b1;
                fill_d          = fill_d == FULL ? fill_d : fill_d + 1'b1;
                if (fill_d == FULL) begin
                    dout_d   = 8'(sum_d >> DEPTH_LOG2);
                    valid_d  = 1'b1;
                    update_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            en_q         <= 1'b0;
            sample_q     <= '0;
            pend_q       <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            reject_run_q <= '0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            outlier_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            en_q         <= enable;
            sample_q     <= sample_d;
            pend_q       <= pend_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            sum_q        <= sum_d;
            reject_run_q <= reject_run_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            outlier_q    <= outlier_d;
        end
    end

    assign distance_out = dout_q;
    assign valid        = valid_q;
    assign update       = update_q;
    assign outlier      = outlier_q;
endmodule

// File: tb/tb_ultrasonic_distance_filter.sv
// tb_ultrasonic_distance_filter: scenario tasks checked against a queue-based window model
module tb_ultrasonic_distance_filter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] distance_in = 8'd0;
    logic [7:0] distance_out;
    logic       valid, update, outlier;
    int         nvec = 0;
    int         nerr = 0;
    int         win[$];
    int         m_out = 0;
    int         m_run = 0;
    bit         m_valid = 1'b0;

    ultrasonic_distance_filter #(.SAMPLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .distance_in(distance_in), .enable(enable),
        .distance_out(distance_out), .valid(valid), .update(update), .outlier(outlier)
    );

    always #5 clk = ~clk;

    task automatic m_flush();
        win.delete();
        m_valid = 1'b0;
        m_run = 0;
    endtask

    task automatic model(input int s, output logic [10:0] e);
        int d, sum;
        bit upd, outl, rej;
        upd = 1'b0;
        outl = 1'b0;
        d = s - m_out;
        if (d < 0) d = -d;
        rej = m_valid && d > 40;
        if (rej && m_run < 3) begin
            m_run++;
            outl = 1'b1;
        end else begin
            if (rej) m_flush();
            m_run = 0;
            win.push_back(s);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                m_out = sum / 4;
                m_valid = 1'b1;
                upd = 1'b1;
            end
        end
        e = {8'(m_out), m_valid, upd, outl};
    endtask

    task automatic step(input int v, output logic [10:0] obs, output bit quiet);
        distance_in = 8'(v);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (update || outlier) quiet = 1'b0;
        end
        @(negedge clk);
        obs = {distance_out, valid, update, outlier};
    endtask

    task automatic restart();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        m_flush();
    endtask

    task automatic test_reset();
        logic [10:0] obs, exp;
        bit q;
        repeat (2) @(negedge clk);
        nvec++;
        if ({distance_out, valid, update, outlier} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_por: got %h want 000", {distance_out, valid, update, outlier});
        end
        reset = 1'b1;
        @(negedge clk);
        restart();
        for (int i = 0; i < 5; i++) begin
            step(100, obs, q);
            model(100, exp);
        end
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL reset_pre: got %h want %h", obs, exp);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_flush();
        m_out = 0;
        nvec++;
        if ({distance_out, valid, update, outlier} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_async: got %h want 000", {distance_out, valid, update, outlier});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(60 + i, obs, q);
            model(60 + i, exp);
            nvec += 2;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL reset_refill[%0d]: got %h want %h", i, obs, exp);
            end
            if (!q) begin
                nerr++;
                $display("FAIL reset_gap[%0d]: strobe=1 want 0", i);
            end
        end
    endtask

    task automatic test_constant();
        logic [10:0] obs, exp;
        bit q;
        restart();
        for (int i = 0; i < 7; i++) begin
            step(100, obs, q);
            model(100, exp);
            nvec += 2;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL const[%0d]: got %h want %h", i, obs, exp);
            end
            if (!q) begin
                nerr++;
                $display("FAIL const_gap[%0d]: strobe=1 want 0", i);
            end
        end
    endtask

    task automatic test_ramp();
        logic [10:0] obs, exp;
        bit q;
        int vals[6] = '{10, 20, 30, 40, 50, 61};
        restart();
        foreach (vals[i]) begin
            step(vals[i], obs, q);
            model(vals[i], exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL ramp[%0d]: got %h want %h", i, obs, exp);
            end
        end
        nvec++;
        if (distance_out !== 8'd45) begin
            nerr++;
            $display("FAIL ramp_trunc: got %0d want 45", distance_out);
        end
    endtask

    task automatic test_outlier();
        logic [10:0] obs, exp;
        bit q;
        int vals[11] = '{100, 100, 100, 100, 200, 200, 200, 200, 200, 200, 200};
        int edge_vals[6] = '{100, 100, 100, 100, 140, 150};
        restart();
        foreach (vals[i]) begin
            step(vals[i], obs, q);
            model(vals[i], exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL outlier[%0d]: got %h want %h", i, obs, exp);
            end
        end
        restart();
        foreach (edge_vals[i]) begin
            step(edge_vals[i], obs, q);
            model(edge_vals[i], exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL jump_edge[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_enable();
        logic [10:0] obs, exp;
        bit q;
        restart();
        for (int i = 0; i < 4; i++) begin
            step(80, obs, q);
            model(80, exp);
        end
        distance_in = 8'd88;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        model(88, exp);
        nvec++;
        if ({distance_out, valid, update, outlier} !== exp) begin
            nerr++;
            $display("FAIL enable_fall: got %h want %h", {distance_out, valid, update, outlier}, exp);
        end
        for (int i = 0; i < 20; i++) begin
            distance_in = 8'($urandom);
            @(negedge clk);
            nvec++;
            if ({distance_out, valid, update, outlier} !== {8'(m_out), m_valid, 2'b00}) begin
                nerr++;
                $display("FAIL enable_hold[%0d]: got %h want %h", i,
                         {distance_out, valid, update, outlier}, {8'(m_out), m_valid, 2'b00});
            end
        end
        enable = 1'b1;
        @(negedge clk);
        m_flush();
        nvec++;
        if ({distance_out, valid} !== {8'(m_out), 1'b0}) begin
            nerr++;
            $display("FAIL enable_flush: got %h want %h", {distance_out, valid}, {8'(m_out), 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            step(90, obs, q);
            model(90, exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL enable_refill[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_saturation();
        logic [10:0] obs, exp;
        bit q;
        restart();
        for (int i = 0; i < 4; i++) begin
            step(255, obs, q);
            model(255, exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL sat_high[%0d]: got %h want %h", i, obs, exp);
            end
        end
        restart();
        for (int i = 0; i < 5; i++) begin
            step(0, obs, q);
            model(0, exp);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL sat_low[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        bit q;
        int v, r;
        int deltas[4] = '{40, -40, 41, -41};
        restart();
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) v = int'($urandom_range(0, 255));
            else if (r < 4) v = m_out + deltas[$urandom_range(0, 3)];
            else v = m_out + int'($urandom_range(0, 60)) - 30;
            v = v < 0 ? 0 : (v > 255 ? 255 : v);
            step(v, obs, q);
            model(v, exp);
            nvec += 2;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL random[%0d] in=%0d: got %h want %h", i, v, obs, exp);
            end
            if (!q) begin
                nerr++;
                $display("FAIL random_gap[%0d]: strobe=1 want 0", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_outlier();
        test_enable();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
